// File: rtl/agu_hash_param.sv
// ---------------------------------------------------------------------------
// agu_hash_param
//
// Parametrised address generation unit for the hash (SHAKE) output buffer.
// Steps an address/bias pair for the sampling controller, between the Keccak
// squeeze controller and the S/E/B buffer RAM address mux.
//
// Step patterns (mode):
//   000 / 010  linear over [0..loop], bias counts passes
//   001        bias counts every step, address advances once per bias cycle
//   011        strided by STRIDE, folded back into [0..loop]
//   100        free-running address modulo 2^ADDR_W
//   101        interleaved: low bias bits are the phase, address moves by
//              2^ILV_LOG2 once per full phase cycle
//   110 / 111  reserved, stepping is a no-op
//
// Optional feature macro: AGU_HASH_PASS_LIMIT_EN
//   When defined, wrap events are counted and generation freezes (done=1)
//   once PASS_LIMIT wraps have occurred. When undefined, done is tied 0.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   addr_clr     synchronous clear of address/bias/wrap/pass state
//   add_en       advance one step
//   mode[2:0]    step pattern
//   level[1:0]   security level, selects the loop bound
//   addr_output  buffer address (registered)
//   bias         lane/pass select (registered)
//   wrap         one-cycle pulse after a wrapping step
//   done         sticky pass-limit reached
// ---------------------------------------------------------------------------
module agu_hash_param #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned BIAS_W     = 3,
   parameter int unsigned LOOP_L1    = 1343,
   parameter int unsigned LOOP_L2    = 975,
   parameter int unsigned LOOP_L3    = 639,
   parameter int unsigned ILV_LOG2   = 1,
   parameter int unsigned STRIDE     = 3,
   parameter int unsigned PASS_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              addr_clr,
   input  logic              add_en,
   input  logic [2:0]        mode,
   input  logic [1:0]        level,
   output logic [ADDR_W-1:0] addr_output,
   output logic [BIAS_W-1:0] bias,
   output logic              wrap,
   output logic              done
);

   typedef enum logic [2:0] {
      MODE_S      = 3'b000,
      MODE_EP     = 3'b001,
      MODE_E      = 3'b010,
      MODE_STRIDE = 3'b011,
      MODE_B      = 3'b100,
      MODE_BI     = 3'b101,
      MODE_RSV6   = 3'b110,
      MODE_RSV7   = 3'b111
   } mode_e;

   localparam int unsigned AH_W = ADDR_W - ILV_LOG2;   // interleaved address index width
   localparam int unsigned BH_W = BIAS_W - ILV_LOG2;   // bias bits above the phase

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BIAS_W-1:0] bias_q, bias_d;
   logic              wrap_q;
   logic              wrap_evt;
   logic              frozen;

   logic [ADDR_W-1:0] loop;
   mode_e             mode_sel;

   // strided-mode helpers; the sum carries one extra bit so the compare
   // against loop cannot alias when addr sits near the top of the range
   logic [ADDR_W:0]   stride_sum;
   logic [ADDR_W-1:0] stride_fold;

   // interleaved-mode helpers
   logic [AH_W-1:0]     ilv_idx;
   logic [ILV_LOG2-1:0] ilv_phase;
   logic [BH_W-1:0]     ilv_bias_hi;
   logic [BH_W-1:0]     ilv_bias_hi_d;

   // ------------------------------------------------------------------------
   // loop bound from the current level (combinational, so a level change
   // mid-pass is seen by the very next step)
   // ------------------------------------------------------------------------
   always_comb begin
      loop = '0;
      case (level)
         2'b01:   loop = ADDR_W'(LOOP_L1);
         2'b10:   loop = ADDR_W'(LOOP_L2);
         2'b11:   loop = ADDR_W'(LOOP_L3);
         default: loop = '0;
      endcase
   end

   assign mode_sel    = mode_e'(mode);
   assign stride_sum  = {1'b0, addr_q} + (ADDR_W+1)'(STRIDE);
   // s - (loop+1) truncated to ADDR_W bits; modulo arithmetic lets this be
   // formed directly at ADDR_W width
   assign stride_fold = addr_q + ADDR_W'(STRIDE) - loop - ADDR_W'(1);

   assign ilv_idx     = addr_q[ADDR_W-1:ILV_LOG2];
   assign ilv_phase   = bias_q[ILV_LOG2-1:0];
   assign ilv_bias_hi = bias_q[BIAS_W-1:ILV_LOG2];

   // ------------------------------------------------------------------------
   // next-state for address / bias and the wrap event of this step
   // ------------------------------------------------------------------------
   always_comb begin
      addr_d        = addr_q;
      bias_d        = bias_q;
      wrap_evt      = 1'b0;
      ilv_bias_hi_d = ilv_bias_hi;

      if (add_en && !frozen) begin
         case (mode_sel)
            MODE_S, MODE_E: begin
               // >= rather than == so a level lowered mid-pass still wraps
               if (addr_q >= loop) begin
                  addr_d   = '0;
                  bias_d   = bias_q + BIAS_W'(1);
                  wrap_evt = 1'b1;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end

            MODE_EP: begin
               bias_d = bias_q + BIAS_W'(1);
               if (&bias_q) begin
                  if (addr_q >= loop) begin
                     addr_d   = '0;
                     wrap_evt = 1'b1;
                  end else begin
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end

            MODE_STRIDE: begin
               if (stride_sum > {1'b0, loop}) begin
                  addr_d   = stride_fold;
                  bias_d   = bias_q + BIAS_W'(1);
                  wrap_evt = 1'b1;
               end else begin
                  addr_d = stride_sum[ADDR_W-1:0];
               end
            end

            MODE_B: begin
               addr_d   = addr_q + ADDR_W'(1);
               wrap_evt = &addr_q;
            end

            MODE_BI: begin
               // low address bits belong to the lane and are left untouched
               if (&ilv_phase) begin
                  if ({{ILV_LOG2{1'b0}}, ilv_idx} >= loop) begin
                     addr_d        = {{AH_W{1'b0}}, addr_q[ILV_LOG2-1:0]};
                     ilv_bias_hi_d = ilv_bias_hi + BH_W'(1);
                     wrap_evt      = 1'b1;
                  end else begin
                     addr_d = {ilv_idx + AH_W'(1), addr_q[ILV_LOG2-1:0]};
                  end
               end
               bias_d = {ilv_bias_hi_d, ilv_phase + ILV_LOG2'(1)};
            end

            default: begin
               addr_d = addr_q;
               bias_d = bias_q;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // address / bias / wrap registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || addr_clr) begin
         addr_q <= '0;
         bias_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         bias_q <= bias_d;
         wrap_q <= wrap_evt;
      end
   end

`ifdef AGU_HASH_PASS_LIMIT_EN
   // ------------------------------------------------------------------------
   // pass limiter: counts wrap events, freezes stepping at PASS_LIMIT
   // ------------------------------------------------------------------------
   localparam int unsigned PC_W = $clog2(PASS_LIMIT + 1);

   logic [PC_W-1:0] pass_q, pass_d;
   logic            done_q, done_d;

   assign frozen = done_q;

   always_comb begin
      pass_d = pass_q;
      done_d = done_q;
      // wrap_evt is already gated by frozen, so no count past the limit
      if (wrap_evt) begin
         pass_d = pass_q + PC_W'(1);
         if (pass_d == PC_W'(PASS_LIMIT)) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || addr_clr) begin
         pass_q <= '0;
         done_q <= 1'b0;
      end else begin
         pass_q <= pass_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
`else
   assign frozen = 1'b0;
   assign done   = 1'b0;
`endif

   assign addr_output = addr_q;
   assign bias        = bias_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_agu_hash_param.sv
module tb_agu_hash_param;

   localparam int ADDR_W     = 12;
   localparam int BIAS_W     = 3;
   localparam int LOOP_L1    = 1343;
   localparam int LOOP_L2    = 975;
   localparam int LOOP_L3    = 639;
   localparam int ILV_LOG2   = 1;
   localparam int STRIDE     = 3;
   localparam int PASS_LIMIT = 8;

   localparam int AMAX = 1 << ADDR_W;
   localparam int BMAX = 1 << BIAS_W;
   localparam int IL   = 1 << ILV_LOG2;

   logic              clk = 1'b0;
   logic              rst, addr_clr, add_en;
   logic [2:0]        mode;
   logic [1:0]        level;
   logic [ADDR_W-1:0] addr_output;
   logic [BIAS_W-1:0] bias;
   logic              wrap, done;

   int vectors     = 0;
   int miscompares = 0;

   // reference state
   int m_addr, m_bias, m_wrap, m_done, m_pass;

   always #5 clk = ~clk;

   agu_hash_param #(
      .ADDR_W(ADDR_W), .BIAS_W(BIAS_W), .LOOP_L1(LOOP_L1), .LOOP_L2(LOOP_L2),
      .LOOP_L3(LOOP_L3), .ILV_LOG2(ILV_LOG2), .STRIDE(STRIDE), .PASS_LIMIT(PASS_LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .addr_clr(addr_clr), .add_en(add_en),
      .mode(mode), .level(level), .addr_output(addr_output), .bias(bias),
      .wrap(wrap), .done(done)
   );

   function automatic int loop_of(input int l);
      case (l)
         1:       return LOOP_L1;
         2:       return LOOP_L2;
         3:       return LOOP_L3;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // behavioural reference: one clock edge worth of rules in integer arithmetic
   task automatic model_step(input bit r, input bit c, input bit e, input int m, input int l);
      int lp, w, s, ph, hi;
      lp = loop_of(l);
      w  = 0;
      if (r || c) begin
         m_addr = 0; m_bias = 0; m_wrap = 0; m_done = 0; m_pass = 0;
         return;
      end
      if (e && m_done == 0) begin
         case (m)
            0, 2: begin
               if (m_addr >= lp) begin m_addr = 0; m_bias = (m_bias + 1) % BMAX; w = 1; end
               else m_addr = m_addr + 1;
            end
            1: begin
               if (m_bias == BMAX - 1) begin
                  if (m_addr >= lp) begin m_addr = 0; w = 1; end
                  else m_addr = m_addr + 1;
               end
               m_bias = (m_bias + 1) % BMAX;
            end
            3: begin
               s = m_addr + STRIDE;
               if (s > lp) begin
                  m_addr = (s - (lp + 1)) % AMAX;
                  m_bias = (m_bias + 1) % BMAX;
                  w = 1;
               end else m_addr = s;
            end
            4: begin
               if (m_addr == AMAX - 1) begin m_addr = 0; w = 1; end
               else m_addr = m_addr + 1;
            end
            5: begin
               ph = m_bias % IL;
               hi = m_bias / IL;
               if (ph == IL - 1) begin
                  if (m_addr / IL >= lp) begin
                     m_addr = m_addr % IL;
                     hi = (hi + 1) % (BMAX / IL);
                     w = 1;
                  end else m_addr = (m_addr + IL) % AMAX;
               end
               m_bias = hi * IL + (ph + 1) % IL;
            end
            default: ;
         endcase
`ifdef AGU_HASH_PASS_LIMIT_EN
         if (w != 0) begin
            m_pass = m_pass + 1;
            if (m_pass == PASS_LIMIT) m_done = 1;
         end
`endif
      end
      m_wrap = w;
   endtask

   task automatic cyc(input bit r, input bit c, input bit e, input int m, input int l);
      rst = r; addr_clr = c; add_en = e; mode = 3'(m); level = 2'(l);
      @(posedge clk);
      model_step(r, c, e, m, l);
      #1;
      chk("addr", 32'(addr_output), 32'(m_addr));
      chk("bias", 32'(bias), 32'(m_bias));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("done", 32'(done), 32'(m_done));
   endtask

   initial begin
      bit r, c, e;
      int m, l;
      rst = 1'b1; addr_clr = 1'b0; add_en = 1'b0; mode = '0; level = '0;
      m_addr = 0; m_bias = 0; m_wrap = 0; m_done = 0; m_pass = 0;

      // reset, then five linear steps
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      chk("rst_addr", 32'(addr_output), 0);
      chk("rst_done", 32'(done), 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1);
      chk("lin5_addr", 32'(addr_output), 5);
      chk("lin5_bias", 32'(bias), 0);
      cyc(0, 1, 1, 0, 1);
      chk("clr_addr", 32'(addr_output), 0);
      chk("clr_wrap", 32'(wrap), 0);

      // level 11 full pass
      for (int i = 0; i < 640; i++) cyc(0, 0, 1, 0, 3);
      chk("l3_pass_addr", 32'(addr_output), 0);
      chk("l3_pass_bias", 32'(bias), 1);
      chk("l3_pass_wrap", 32'(wrap), 1);
      cyc(0, 0, 1, 0, 3);
      chk("l3_after_wrap", 32'(wrap), 0);

      // level drop mid-pass
      cyc(0, 1, 0, 0, 1);
      for (int i = 0; i < 900; i++) cyc(0, 0, 1, 0, 1);
      chk("l1_900", 32'(addr_output), 900);
      cyc(0, 0, 1, 0, 3);
      chk("lvl_drop_addr", 32'(addr_output), 0);
      chk("lvl_drop_bias", 32'(bias), 1);
      chk("lvl_drop_wrap", 32'(wrap), 1);

      // mode 001 at level 00
      cyc(0, 1, 0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0);
      chk("ep_bias", 32'(bias), 0);
      chk("ep_wrap", 32'(wrap), 1);

      // strided fold at the loop end
      cyc(0, 1, 0, 0, 3);
      for (int i = 0; i < 638; i++) cyc(0, 0, 1, 0, 3);
      cyc(0, 0, 1, 3, 3);
      chk("stride_addr", 32'(addr_output), 1);
      chk("stride_wrap", 32'(wrap), 1);
      cyc(0, 0, 1, 3, 3);
      chk("stride_next", 32'(addr_output), 4);

      // reset mid-pass
      cyc(1, 0, 1, 3, 3);
      chk("midrst_addr", 32'(addr_output), 0);

      // interleaved full pass
      for (int i = 0; i < 1280; i++) begin
         cyc(0, 0, 1, 5, 3);
         chk("ilv_lsb", 32'(addr_output[0]), 0);
      end
      chk("ilv_wrap_addr", 32'(addr_output), 0);
      chk("ilv_wrap_bias", 32'(bias), 2);
      chk("ilv_wrap", 32'(wrap), 1);

      // pass limit at level 00
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
      chk("pl_bias", 32'(bias), 0);
`ifdef AGU_HASH_PASS_LIMIT_EN
      chk("pl_done", 32'(done), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
      chk("pl_frozen_bias", 32'(bias), 0);
      chk("pl_frozen_wrap", 32'(wrap), 0);
      cyc(0, 1, 0, 0, 0);
      chk("pl_release", 32'(done), 0);
`else
      chk("pl_done", 32'(done), 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
      chk("pl_cycle_bias", 32'(bias), 3);
`endif

      // randomized bursts against the model
      m = 0; l = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 31) == 0) m = $urandom_range(0, 7);
         if ($urandom_range(0, 31) == 0) l = $urandom_range(0, 3);
         r = ($urandom_range(0, 299) == 0);
         c = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 3) != 0);
         cyc(r, c, e, m, l);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
